mips_pipeline_hazard_ctrl: RTL

//  Central hazard controller for the 5-stage MIPS pipeline; successor to the EX-only forwarding logic.

---
 rtl/mips_pipeline_hazard_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/mips_pipeline_hazard_ctrl.sv
// mips_pipeline_hazard_ctrl: load-use stall, redirect flush, hold, EX forwarding and ID bypass for the 5-stage MIPS pipe.
// Define PERF_CNT_EN to build the saturating stall/flush performance counters.
module mips_pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hold_i,
    input  logic                  redirect_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_use_rs_i,
    input  logic                  id_use_rt_i,
    input  logic [REG_ADDR_W-1:0] id_dest_i,
    input  logic                  id_regwr_i,
    input  logic                  id_memrd_i,
    input  logic [REG_ADDR_W-1:0] ex_rs_i,
    input  logic [REG_ADDR_W-1:0] ex_rt_i,
    output logic                  pc_we_o,
    output logic                  if_id_we_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_flush_o,
    output logic                  ex_mem_flush_o,
    output logic [1:0]            fwd_a_o,
    output logic [1:0]            fwd_b_o,
    output logic                  id_byp_a_o,
    output logic                  id_byp_b_o,
    output logic [1:0]            state_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);
    typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2, HOLD = 2'd3} action_t;
    action_t act, stateQ;
    logic exV, exRegWr, exMemRd, memV, memRegWr, memMemRd, wbV, wbRegWr;
    logic [REG_ADDR_W-1:0] exDest, memDest, wbDest;
    logic loadUse, memFwdOk, wbFwdOk;
    always_comb begin
        loadUse = exV && exMemRd && exDest != '0 && id_valid_i &&
                  ((id_use_rs_i && id_rs_i == exDest) || (id_use_rt_i && id_rt_i == exDest));
        act = !reset ? RUN : hold_i ? HOLD : redirect_i ? FLUSH : loadUse ? STALL : RUN;
    end
    assign pc_we_o        = act == RUN || act == FLUSH;
    assign if_id_we_o     = pc_we_o;
    assign if_id_flush_o  = act == FLUSH;
    assign id_ex_flush_o  = act == FLUSH || act == STALL;
    assign ex_mem_flush_o = act == FLUSH;
    assign state_o        = stateQ;
    // A load sitting in MEM has no data yet, so only ALU results forward from there.
    assign memFwdOk = memV && memRegWr && !memMemRd && memDest != '0;
    assign wbFwdOk  = wbV && wbRegWr && wbDest != '0;
    assign fwd_a_o  = (memFwdOk && memDest == ex_rs_i) ? 2'b10 : (wbFwdOk && wbDest == ex_rs_i) ? 2'b01 : 2'b00;
    assign fwd_b_o  = (memFwdOk && memDest == ex_rt_i) ? 2'b10 : (wbFwdOk && wbDest == ex_rt_i) ? 2'b01 : 2'b00;
    assign id_byp_a_o = wbFwdOk && wbDest == id_rs_i;
    assign id_byp_b_o = wbFwdOk && wbDest == id_rt_i;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ   <= RUN;
            {exV, exRegWr, exMemRd, exDest}     <= '0;
            {memV, memRegWr, memMemRd, memDest} <= '0;
            {wbV, wbRegWr, wbDest}              <= '0;
        end else begin
            stateQ <= act;
            if (act != HOLD) begin
                wbV     <= memV;
                wbRegWr <= memRegWr;
                wbDest  <= memDest;
            end
            if (act == RUN || act == STALL) begin
                memV     <= exV;
                memRegWr <= exRegWr;
                memMemRd <= exMemRd;
                memDest  <= exDest;
            end else if (act == FLUSH) begin
                memV <= 1'b0;
            end
            if (act == RUN) begin
                exV     <= id_valid_i;
                exRegWr <= id_regwr_i;
                exMemRd <= id_memrd_i;
                exDest  <= id_dest_i;
            end else if (act != HOLD) begin
                exV <= 1'b0;
            end
        end
    end
`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stallCnt, flushCnt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (act == STALL && stallCnt != '1) stallCnt <= stallCnt + 1'b1;
            if (act == FLUSH && flushCnt != '1) flushCnt <= flushCnt + 1'b1;
        end
    end
    assign stall_cnt_o = stallCnt;
    assign flush_cnt_o = flushCnt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif
endmodule
